// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, flag bit positions, FSM states.
package alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned FLAGS_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'd0;
  localparam logic [OP_W-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NAND = 4'd5;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd6;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd7;
  localparam logic [OP_W-1:0] OP_ABS  = 4'd8;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd9;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd10;
  localparam logic [OP_W-1:0] OP_ASHL = 4'd11;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd12;
  localparam logic [OP_W-1:0] OP_ASHR = 4'd13;
  localparam logic [OP_W-1:0] OP_FADD = 4'd14;
  localparam logic [OP_W-1:0] OP_FMUL = 4'd15;

  // Bit positions inside the {Cout,Negative,Zero,Overflow} flag vector.
  localparam int unsigned FLAG_COUT = 3;
  localparam int unsigned FLAG_NEG  = 2;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_OVF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer advance; callers never push when full or pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives each onto the combinational ALU for a fixed settle
// time, then captures Y/flags and returns them on a valid/ready response stream.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DATA_W-1:0]  cmd_a,
  input  logic [DATA_W-1:0]  cmd_b,
  input  logic [SEL_W-1:0]   cmd_sel,
  input  logic               cmd_cin,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SEL_W-1:0]   alu_sel,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_y,
  input  logic [FLAGS_W-1:0] alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_y,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic [SEL_W-1:0]   rsp_sel,
  output logic               busy
);

  localparam int unsigned CMD_W = 2*DATA_W + SEL_W + 1;
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic               alu_cin_q, alu_cin_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_y_q, rsp_y_d;
  logic [FLAGS_W-1:0] rsp_flags_q, rsp_flags_d;
  logic [SEL_W-1:0]   rsp_sel_q, rsp_sel_d;

  logic               rdy_en_q;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CMD_W-1:0]   fifo_wdata;
  logic [CMD_W-1:0]   fifo_rdata;
  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic [SEL_W-1:0]   head_sel;
  logic               head_cin;

  // Holds cmd_ready low through reset and lets it rise on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign cmd_ready  = rdy_en_q && !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_a, cmd_b, cmd_sel, cmd_cin};
  assign {head_a, head_b, head_sel, head_cin} = fifo_rdata;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic: issue from the FIFO, count the settle window, capture, hand off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    alu_cin_d   = alu_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    rsp_sel_d   = rsp_sel_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_a_d   = head_a;
          alu_b_d   = head_b;
          alu_sel_d = head_sel;
          alu_cin_d = head_cin;
          cnt_d     = CNT_W'(SETTLE_CYC - 1);
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          rsp_y_d     = alu_y;
          rsp_flags_d = alu_flags;
          rsp_sel_d   = alu_sel_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            // Back-to-back issue keeps one response per SETTLE_CYC+1 cycles.
            fifo_pop  = 1'b1;
            alu_a_d   = head_a;
            alu_b_d   = head_b;
            alu_sel_d = head_sel;
            alu_cin_d = head_cin;
            cnt_d     = CNT_W'(SETTLE_CYC - 1);
            state_d   = ST_DRIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and capture registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      alu_cin_q   <= alu_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_sel_q   <= rsp_sel_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_cin   = alu_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_sel   = rsp_sel_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule
